// File: rtl/debounce_pulse.sv
// rtl/debounce_pulse.sv - two-flop synchroniser and debounce FSM with transition strobes and event count
module debounce_pulse #(
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 8,
  parameter int EVT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  output logic             dout,
  output logic             en_pulse,
  output logic             rise,
  output logic             fall,
  output logic [EVT_W-1:0] edge_cnt
);

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [EVT_W-1:0] ONE_EVT  = EVT_W'(1);

  logic             s1;
  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // cnt holds how many consecutive samples of s2 have been seen at the candidate level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= STABLE_LOW;
      cnt      <= '0;
      dout     <= 1'b0;
      en_pulse <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      edge_cnt <= '0;
    end else begin
      en_pulse <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (s2) begin
            state <= WAIT_HIGH;
            cnt   <= ONE_CNT;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s2) begin
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (cnt == LAST_CNT) begin
            state    <= STABLE_HIGH;
            cnt      <= '0;
            dout     <= 1'b1;
            rise     <= 1'b1;
            en_pulse <= 1'b1;
            edge_cnt <= edge_cnt + ONE_EVT;
          end else begin
            cnt <= cnt + ONE_CNT;
          end
        end
        STABLE_HIGH: begin
          if (!s2) begin
            state <= WAIT_LOW;
            cnt   <= ONE_CNT;
          end else begin
            cnt <= '0;
          end
        end
        WAIT_LOW: begin
          if (s2) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == LAST_CNT) begin
            state    <= STABLE_LOW;
            cnt      <= '0;
            dout     <= 1'b0;
            fall     <= 1'b1;
            en_pulse <= 1'b1;
            edge_cnt <= edge_cnt + ONE_EVT;
          end else begin
            cnt <= cnt + ONE_CNT;
          end
        end
        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
